// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg -- shared definitions for the fetch sequencing controller.
//   FULLW            : datapath width (program counter width)
//   DEF_FLUSH_CYCLES : default number of squashed fetch cycles after a redirect
//   fetch_state_t    : controller state encoding (2'd3 is illegal, recovers to INIT)
package fetch_seq_pkg;

  localparam int FULLW = 32;

  localparam int unsigned DEF_FLUSH_CYCLES = 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq.sv
// fetch_seq -- sequencing controller for the 32-bit program counter.
// Each cycle decides whether the PC advances, holds, takes a relative branch
// or loads an absolute target, and produces fetch-valid / flush signals so
// wrong-path fetches are squashed.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   jmp_req, jmp_addr    : absolute redirect (PC write) from writeback
//   br_req, br_off       : taken relative branch and signed byte offset
//   stall_req            : hazard unit requests a PC hold
//   imem_ready           : instruction memory can accept a new address
//   pc_en/pc_reset/pc_we/pc_wd/pc_ib/pc_bv : PC control inputs
//   if_valid             : PC address output is a valid fetch this cycle
//   flush                : kill all younger pipeline stages this cycle
//   busy_flush           : controller is in the FLUSH state
//   stall_cnt, redirect_cnt : performance counters (only with FETCH_SEQ_PERF_EN)
//
// Build option: define FETCH_SEQ_PERF_EN to add the performance counters.
//
// The PC's address output lags its internal counter by one enabled edge, so
// a single enabled edge after a redirect (the FLUSH cycle) brings the target
// onto the address output.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jmp_req,
  input  logic [FULLW-1:0] jmp_addr,
  input  logic             br_req,
  input  logic [FULLW-1:0] br_off,
  input  logic             stall_req,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             pc_reset,
  output logic             pc_we,
  output logic [FULLW-1:0] pc_wd,
  output logic             pc_ib,
  output logic [FULLW-1:0] pc_bv,
  output logic             if_valid,
  output logic             flush,
  output logic             busy_flush
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      redirect_cnt
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  fetch_state_t state_reg, state_next;
  logic [3:0]   flush_cnt_reg, flush_cnt_next;
  logic         redirect;
  logic         redirect_accept;

  assign redirect = jmp_req | br_req;

  always_ff @(posedge clk) begin
    state_reg     <= state_next;
    flush_cnt_reg <= flush_cnt_next;
  end

  always_comb begin
    state_next      = state_reg;
    flush_cnt_next  = flush_cnt_reg;
    pc_en           = 1'b0;
    pc_reset        = 1'b0;
    pc_we           = 1'b0;
    pc_wd           = jmp_addr;
    pc_ib           = 1'b0;
    pc_bv           = br_off;
    if_valid        = 1'b0;
    flush           = 1'b0;
    redirect_accept = 1'b0;

    if (reset) begin
      pc_en          = 1'b1;
      pc_reset       = 1'b1;
      pc_wd          = '0;
      pc_bv          = '0;
      flush          = 1'b1;
      state_next     = INIT;
      flush_cnt_next = 4'd0;
    end else begin
      case (state_reg)
        INIT: begin
          // One enabled edge moves counter 0 onto the address output.
          pc_en      = 1'b1;
          flush      = 1'b1;
          state_next = RUN;
        end
        RUN, FLUSH: begin
          if (redirect) begin
            // Redirects always load, regardless of stall or backpressure.
            redirect_accept = 1'b1;
            pc_en           = 1'b1;
            pc_we           = jmp_req;
            pc_ib           = br_req & ~jmp_req;
            flush           = 1'b1;
            state_next      = FLUSH;
            flush_cnt_next  = FLUSH_LOAD;
          end else if (state_reg == RUN) begin
            pc_en    = imem_ready & ~stall_req;
            if_valid = 1'b1;
          end else begin
            // No valid instruction is held in FLUSH, so stalls do not apply.
            pc_en = imem_ready;
            if (imem_ready) begin
              if (flush_cnt_reg == 4'd0) begin
                state_next = RUN;
              end else begin
                flush_cnt_next = flush_cnt_reg - 4'd1;
              end
            end
          end
        end
        default: begin
          // Illegal encoding: squash and recover through INIT.
          flush          = 1'b1;
          state_next     = INIT;
          flush_cnt_next = 4'd0;
        end
      endcase
    end
  end

  assign busy_flush = (state_reg == FLUSH);

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] redirect_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg    <= 32'd0;
      redirect_cnt_reg <= 32'd0;
    end else begin
      if ((state_reg == RUN) && !pc_en) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (redirect_accept) begin
        redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_reg;
  assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule
